// File: rtl/mem_defines.sv
// Shared definitions for the cache-line memory arbiter.
//   MEM_ACCESS_TIMEOUT : default cycle budget from command issue to burst end
//   sdram_access_len   : default number of 16-bit SDRAM beats per cache line
//   line_t             : 128-bit cache line, word 0 in bits 127:112
//   sdram_addr_t       : 24-bit SDRAM beat address
//   port_id_e          : requester id (D-cache = 0, I-cache = 1)
//   arb_state_e        : arbiter FSM states
package mem_defines;

    localparam int MEM_ACCESS_TIMEOUT = 128;
    localparam int sdram_access_len   = 8;

    typedef logic [127:0] line_t;
    typedef logic [23:0]  sdram_addr_t;

    typedef enum logic {
        PORT_DC = 1'b0,
        PORT_IC = 1'b1
    } port_id_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WR_BURST,
        ST_RD_BURST,
        ST_DONE
    } arb_state_e;

    // Line-aligned byte address to SDRAM beat address; addr[31:25] is dropped.
    function automatic sdram_addr_t line_to_sdram_addr(input logic [31:0] byte_addr);
        return {byte_addr[24:4], 3'b000};
    endfunction

endpackage

// File: rtl/mem_line_serdes.sv
// Cache line <-> 8 x 16-bit beat converter.
//   clk, rst   : clock, synchronous active-high reset
//   load       : capture load_line for writeback and clear the refill line
//   load_line  : line to serialise
//   beat_idx   : current beat number (0 = bits 127:112)
//   wbeat      : beat of the captured line selected by beat_idx
//   shift_en   : shift rbeat into the refill line
//   rbeat      : incoming read beat
//   rline      : assembled refill line (first beat ends up in bits 127:112)
module mem_line_serdes
    import mem_defines::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  line_t       load_line,
    input  logic [2:0]  beat_idx,
    output logic [15:0] wbeat,
    input  logic        shift_en,
    input  logic [15:0] rbeat,
    output line_t       rline
);

    line_t      wline_q, wline_d;
    line_t      rline_q, rline_d;
    logic [6:0] wsel;

    always_comb begin
        wline_d = wline_q;
        rline_d = rline_q;
        if (load) begin
            wline_d = load_line;
            rline_d = '0;
        end else if (shift_en) begin
            rline_d = {rline_q[111:0], rbeat};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wline_q <= '0;
            rline_q <= '0;
        end else begin
            wline_q <= wline_d;
            rline_q <= rline_d;
        end
    end

    // Beat 0 lives in the top 16 bits, so index from the MSB end.
    assign wsel  = {3'd7 - beat_idx, 4'b0000};
    assign wbeat = wline_q[wsel +: 16];
    assign rline = rline_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (D-cache / I-cache) round-robin arbiter onto one SDRAM controller,
// moving whole 128-bit cache lines as bursts of 16-bit beats.
//   clk, rst                 : clock, synchronous active-high reset
//   dc_*/ic_* req,we,addr,wdata : line request, 1 = writeback, byte address, line
//   dc_done/ic_done          : one-cycle completion pulse
//   dc_err/ic_err            : one-cycle timeout pulse, coincident with done
//   rdata                    : refill line, valid with a done pulse of a refill
//   sdram_req/we/addr/ack    : SDRAM command handshake
//   sdram_wdata/wdata_rd     : write beat, pulled once per asserted wdata_rd
//   sdram_rdata/rdata_vld    : read beat, one per asserted rdata_vld
module mem_arbiter
    import mem_defines::*;
#(
    parameter int TIMEOUT   = MEM_ACCESS_TIMEOUT,
    parameter int BURST_LEN = sdram_access_len
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dc_req,
    input  logic        dc_we,
    input  logic [31:0] dc_addr,
    input  line_t       dc_wdata,
    output logic        dc_done,
    output logic        dc_err,
    input  logic        ic_req,
    input  logic        ic_we,
    input  logic [31:0] ic_addr,
    input  line_t       ic_wdata,
    output logic        ic_done,
    output logic        ic_err,
    output line_t       rdata,
    output logic        sdram_req,
    output logic        sdram_we,
    output sdram_addr_t sdram_addr,
    input  logic        sdram_ack,
    output logic [15:0] sdram_wdata,
    input  logic        sdram_wdata_rd,
    input  logic [15:0] sdram_rdata,
    input  logic        sdram_rdata_vld
);

    localparam int         TMO_W     = $clog2(TIMEOUT + 1);
    localparam logic [2:0] LAST_BEAT = 3'(BURST_LEN - 1);

    arb_state_e  state_q, state_d;
    port_id_e    port_q, port_d;
    port_id_e    rr_q, rr_d;
    logic        we_q, we_d;
    sdram_addr_t addr_q, addr_d;
    logic [2:0]  beat_q, beat_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic        err_q, err_d;

    logic        grant, busy, beat_step, timeout_hit, last_step;
    port_id_e    gnt_port;
    logic [31:0] gnt_addr;
    line_t       gnt_line;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{dc_addr[31:25], dc_addr[3:0], ic_addr[31:25], ic_addr[3:0]};

    // Tie goes to the port the pointer favours, i.e. the one not last granted.
    always_comb begin
        grant    = (state_q == ST_IDLE) && (dc_req || ic_req);
        gnt_port = (dc_req && ic_req) ? rr_q : (ic_req ? PORT_IC : PORT_DC);
        gnt_addr = (gnt_port == PORT_DC) ? dc_addr : ic_addr;
        gnt_line = (gnt_port == PORT_DC) ? dc_wdata : ic_wdata;
    end

    always_comb begin
        busy        = (state_q == ST_ISSUE) || (state_q == ST_WR_BURST) ||
                      (state_q == ST_RD_BURST);
        beat_step   = ((state_q == ST_WR_BURST) && sdram_wdata_rd) ||
                      ((state_q == ST_RD_BURST) && sdram_rdata_vld);
        timeout_hit = busy && (tmo_q == TMO_W'(TIMEOUT - 1));
        last_step   = beat_step && (beat_q == LAST_BEAT);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            port_q  <= PORT_DC;
            rr_q    <= PORT_DC;
            we_q    <= 1'b0;
            addr_q  <= '0;
            beat_q  <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            rr_q    <= rr_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            beat_q  <= beat_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; timeout takes priority over any handshake that cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (grant) state_d = ST_ISSUE;
            ST_ISSUE: begin
                if (timeout_hit)    state_d = ST_DONE;
                else if (sdram_ack) state_d = we_q ? ST_WR_BURST : ST_RD_BURST;
            end
            ST_WR_BURST,
            ST_RD_BURST: if (timeout_hit || last_step) state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Transaction latch, round-robin pointer and counters
    always_comb begin
        port_d = port_q;
        rr_d   = rr_q;
        we_d   = we_q;
        addr_d = addr_q;
        beat_d = beat_q;
        tmo_d  = tmo_q;
        err_d  = timeout_hit;
        if (grant) begin
            port_d = gnt_port;
            rr_d   = (gnt_port == PORT_DC) ? PORT_IC : PORT_DC;
            we_d   = (gnt_port == PORT_DC) ? dc_we : ic_we;
            addr_d = line_to_sdram_addr(gnt_addr);
            beat_d = '0;
            tmo_d  = '0;
        end else if (busy) begin
            tmo_d = tmo_q + 1'b1;
            if (beat_step) beat_d = beat_q + 1'b1;
        end
    end

    // Outputs
    always_comb begin
        sdram_req = (state_q == ST_ISSUE);
        dc_done   = (state_q == ST_DONE) && (port_q == PORT_DC);
        ic_done   = (state_q == ST_DONE) && (port_q == PORT_IC);
        dc_err    = dc_done && err_q;
        ic_err    = ic_done && err_q;
    end

    assign sdram_we   = we_q;
    assign sdram_addr = addr_q;

    mem_line_serdes u_serdes (
        .clk       (clk),
        .rst       (rst),
        .load      (grant),
        .load_line (gnt_line),
        .beat_idx  (beat_q),
        .wbeat     (sdram_wdata),
        .shift_en  ((state_q == ST_RD_BURST) && sdram_rdata_vld),
        .rbeat     (sdram_rdata),
        .rline     (rdata)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    import mem_defines::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        dc_req, dc_we, ic_req, ic_we;
    logic [31:0] dc_addr, ic_addr;
    line_t       dc_wdata, ic_wdata, rdata;
    logic        dc_done, dc_err, ic_done, ic_err;
    logic        sdram_req, sdram_we, sdram_ack;
    sdram_addr_t sdram_addr;
    logic [15:0] sdram_wdata, sdram_rdata;
    logic        sdram_wdata_rd, sdram_rdata_vld;

    mem_arbiter #(.TIMEOUT(128), .BURST_LEN(8)) dut (
        .clk(clk), .rst(rst),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_done(dc_done), .dc_err(dc_err),
        .ic_req(ic_req), .ic_we(ic_we), .ic_addr(ic_addr), .ic_wdata(ic_wdata),
        .ic_done(ic_done), .ic_err(ic_err),
        .rdata(rdata),
        .sdram_req(sdram_req), .sdram_we(sdram_we), .sdram_addr(sdram_addr),
        .sdram_ack(sdram_ack),
        .sdram_wdata(sdram_wdata), .sdram_wdata_rd(sdram_wdata_rd),
        .sdram_rdata(sdram_rdata), .sdram_rdata_vld(sdram_rdata_vld)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic  port;      // 0 = dc, 1 = ic
        logic  err;
        logic  chk_data;
        line_t data;
    } exp_t;

    exp_t        exp_q[$];
    sdram_addr_t cmd_addr_q[$];
    logic        cmd_we_q[$];
    logic [15:0] wbeat_q[$];

    int checks = 0;
    int passed = 0;

    // SDRAM model controls and status
    logic [15:0] rd_beats[8];
    bit          ack_en = 1'b1;
    bit          gap_en = 1'b0;
    int          stray_n = 0;
    int          m_beat = 0;
    int          done_cnt = 0;
    int          req_cycles = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // SDRAM controller model: acks commands, checks them against the command
    // queue, then pulls write beats (checked) or returns rd_beats.
    initial begin : sdram_model
        int  m_state;
        bit  m_we, m_skip;
        m_state = 0; m_we = 0; m_skip = 0;
        sdram_ack = 0; sdram_wdata_rd = 0; sdram_rdata_vld = 0; sdram_rdata = '0;
        forever begin
            @(negedge clk);
            sdram_ack = 0; sdram_wdata_rd = 0; sdram_rdata_vld = 0;
            if (rst) begin
                m_state = 0;
                m_beat  = 0;
            end else begin
                if (m_state == 0) begin
                    if (sdram_req && ack_en) begin
                        sdram_ack = 1;
                        m_state = 1;
                    end else if (stray_n > 0) begin
                        sdram_rdata_vld = 1;
                        sdram_rdata = 16'hDEAD ^ 16'(stray_n);
                        stray_n--;
                    end
                end else begin
                    if (m_state == 1) begin
                        if (cmd_addr_q.size() == 0) begin
                            check("cmd_unexpected", 1'b1, 1'b0);
                        end else begin
                            check("cmd_addr", sdram_addr, cmd_addr_q.pop_front());
                            check("cmd_we", sdram_we, cmd_we_q.pop_front());
                        end
                        m_we = sdram_we; m_beat = 0; m_skip = 0; m_state = 2;
                    end
                    if (gap_en && m_skip) begin
                        m_skip = 0;
                    end else begin
                        m_skip = 1;
                        if (m_we) begin
                            sdram_wdata_rd = 1;
                            if (wbeat_q.size() == 0) check("wbeat_unexpected", sdram_wdata, 16'h0);
                            else check("wbeat", sdram_wdata, wbeat_q.pop_front());
                        end else begin
                            sdram_rdata_vld = 1;
                            sdram_rdata = rd_beats[m_beat];
                        end
                        m_beat++;
                        if (m_beat == 8) m_state = 0;
                    end
                end
            end
        end
    end

    // Completion monitor: pops the scoreboard on every done pulse.
    initial begin : done_monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (sdram_req) req_cycles++;
                if (dc_done || ic_done) begin
                    done_cnt++;
                    if (exp_q.size() == 0) begin
                        check("done_unexpected", {dc_done, ic_done}, 2'b00);
                    end else begin
                        e = exp_q.pop_front();
                        check("done_port", {dc_done, ic_done}, e.port ? 2'b01 : 2'b10);
                        check("done_err", {dc_err, ic_err},
                              e.err ? (e.port ? 2'b01 : 2'b10) : 2'b00);
                        if (e.chk_data) check("rdata", rdata, e.data);
                    end
                end else if (dc_err || ic_err) begin
                    check("err_without_done", {dc_err, ic_err}, 2'b00);
                end
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_dones(input string name, input int target, input int budget);
        for (int i = 0; i < budget && done_cnt < target; i++) tick(1);
        check(name, done_cnt, target);
    endtask

    task automatic set_beats(input logic [15:0] base, input logic [15:0] step, output line_t line);
        line = '0;
        for (int i = 0; i < 8; i++) begin
            rd_beats[i] = base + step * 16'(i);
            line = {line[111:0], rd_beats[i]};
        end
    endtask

    task automatic expect_done(input logic port, input logic err, input logic chk, input line_t data);
        exp_t e;
        e.port = port; e.err = err; e.chk_data = chk; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic expect_cmd(input sdram_addr_t a, input logic we);
        cmd_addr_q.push_back(a);
        cmd_we_q.push_back(we);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        line_t line;
        int    base;
        rst = 1; dc_req = 0; dc_we = 0; dc_addr = '0; dc_wdata = '0;
        ic_req = 0; ic_we = 0; ic_addr = '0; ic_wdata = '0;
        tick(3);

        // Reset state
        check("rst_done", {dc_done, ic_done, dc_err, ic_err}, 4'h0);
        check("rst_sdram_req", sdram_req, 1'b0);
        check("rst_sdram_we", sdram_we, 1'b0);
        check("rst_sdram_addr", sdram_addr, 24'h0);
        check("rst_sdram_wdata", sdram_wdata, 16'h0);
        check("rst_rdata", rdata, 128'h0);
        rst = 0;
        tick(2);

        // D-cache refill of 0x0000_1230
        set_beats(16'h1111, 16'h1111, line);
        expect_cmd(24'h000918, 1'b0);
        expect_done(1'b0, 1'b0, 1'b1, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
        dc_we = 0; dc_addr = 32'h0000_1230; dc_req = 1;
        wait_dones("dc_refill_done", 1, 60);
        dc_req = 0;
        tick(3);

        // I-cache writeback of 0x0100_0040 with SDRAM pulling every other cycle
        gap_en = 1;
        ic_wdata = 128'hA0A0_A1A1_A2A2_A3A3_A4A4_A5A5_A6A6_A7A7;
        for (int i = 0; i < 8; i++) wbeat_q.push_back(16'hA0A0 + 16'h0101 * 16'(i));
        expect_cmd(24'h800020, 1'b1);
        expect_done(1'b1, 1'b0, 1'b0, '0);
        ic_we = 1; ic_addr = 32'h0100_0040; ic_req = 1;
        wait_dones("ic_wb_done", 2, 80);
        ic_req = 0; ic_we = 0;
        check("ic_wb_all_beats", wbeat_q.size(), 0);
        gap_en = 0;
        tick(3);

        // Both requesters raised together and held: dc, ic, dc, ic
        set_beats(16'h0001, 16'h0001, line);
        for (int i = 0; i < 2; i++) begin
            expect_cmd(24'h000080, 1'b0);
            expect_done(1'b0, 1'b0, 1'b1, line);
            expect_cmd(24'h000100, 1'b0);
            expect_done(1'b1, 1'b0, 1'b1, line);
        end
        dc_addr = 32'h0000_0100; ic_addr = 32'h0000_0200;
        dc_req = 1; ic_req = 1;
        wait_dones("rr_done", 6, 200);
        dc_req = 0; ic_req = 0;
        check("rr_all_cmds", cmd_addr_q.size(), 0);
        tick(3);

        // No ack: timeout after 128 cycles of sdram_req
        ack_en = 0;
        base = req_cycles;
        expect_done(1'b0, 1'b1, 1'b0, '0);
        dc_addr = 32'h0000_0000; dc_req = 1;
        wait_dones("timeout_done", 7, 200);
        dc_req = 0;
        check("timeout_req_cycles", req_cycles - base, 128);
        tick(1);
        check("timeout_idle_req", sdram_req, 1'b0);
        ack_en = 1;
        tick(2);

        // Reset at read beat 4, then a clean refill
        set_beats(16'hB001, 16'h0001, line);
        expect_cmd(24'h000020, 1'b0);
        expect_done(1'b0, 1'b0, 1'b1, line);
        dc_addr = 32'h0000_0040; dc_req = 1;
        for (int i = 0; i < 40 && m_beat != 4; i++) tick(1);
        check("abort_reached_beat4", m_beat, 4);
        rst = 1;
        exp_q.delete(); cmd_addr_q.delete(); cmd_we_q.delete();
        tick(2);
        dc_req = 0;
        rst = 0;
        check("abort_rdata_cleared", rdata, 128'h0);
        tick(2);
        check("abort_no_done", done_cnt, 7);
        set_beats(16'hC1C1, 16'h0101, line);
        expect_cmd(24'h000028, 1'b0);
        expect_done(1'b0, 1'b0, 1'b1, 128'hC1C1_C2C2_C3C3_C4C4_C5C5_C6C6_C7C7_C8C8);
        dc_addr = 32'h0000_0050; dc_req = 1;
        wait_dones("post_abort_done", 8, 60);
        dc_req = 0;
        tick(2);

        // Stray read strobes while idle must not disturb rdata
        stray_n = 5;
        tick(8);
        check("stray_rdata_kept", rdata, 128'hC1C1_C2C2_C3C3_C4C4_C5C5_C6C6_C7C7_C8C8);
        set_beats(16'hD1D1, 16'h0101, line);
        expect_cmd(24'h000030, 1'b0);
        expect_done(1'b0, 1'b0, 1'b1, 128'hD1D1_D2D2_D3D3_D4D4_D5D5_D6D6_D7D7_D8D8);
        dc_addr = 32'h0000_0060; dc_req = 1;
        wait_dones("stray_refill_done", 9, 60);
        dc_req = 0;
        tick(4);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default MEM_ACCESS_TIMEOUT (128), max cycles from command issue to burst completion.
REQ-002 SHALL have parameter BURST_LEN, default sdram_access_len (8), 16-bit SDRAM beats per cache line.
REQ-003 SHALL have port clk  in  1  sole clock, all logic rising-edge.
REQ-004 SHALL have port rst  in  1  synchronous active-high reset.
REQ-005 SHALL have ports dc_req/ic_req  in  1  per-requester line request (port 0 = D-cache, port 1 = I-cache).
REQ-006 SHALL have ports dc_we/ic_we  in  1  1 = line writeback, 0 = line refill.
REQ-007 SHALL have ports dc_addr/ic_addr  in  32  byte address, low 4 bits ignored.
REQ-008 SHALL have ports dc_wdata/ic_wdata  in  128  line to write (w0 in bits 127:112).
REQ-009 SHALL have ports dc_done/ic_done  out  1  one-cycle completion pulse.
REQ-010 SHALL have ports dc_err/ic_err  out  1  one-cycle timeout pulse, coincident with done.
REQ-011 SHALL have port rdata  out  128  refill line, valid while a done pulse is high and we was 0.
REQ-012 SHALL have ports sdram_req  out  1, sdram_we  out  1, sdram_addr  out  24  (sdram_addr_t), SDRAM command.
REQ-013 SHALL have port sdram_ack  in  1  command accepted.
REQ-014 SHALL have ports sdram_wdata  out  16, sdram_wdata_rd  in  1  (controller pulls one beat per asserted cycle).
REQ-015 SHALL have ports sdram_rdata  in  16, sdram_rdata_vld  in  1  (one read beat per asserted cycle).

Function
REQ-016 SHALL implement FSM IDLE -> ISSUE -> (WR_BURST | RD_BURST) -> DONE -> IDLE.
REQ-017 In IDLE with any req high, SHALL grant round-robin: pointer favours the port not last granted; after reset, D-cache wins a tie.
REQ-018 On grant, SHALL latch port id, we, addr[24:4] and wdata; later input changes are ignored until done.
REQ-019 sdram_addr SHALL be {addr[24:4], 3'b000}; addr[31:25] is dropped without error.
REQ-020 In ISSUE, sdram_req SHALL be held high until the sdram_ack cycle, then drop the following cycle.
REQ-021 WR_BURST SHALL present beats w0..w7 in order on sdram_wdata, advancing on each sdram_wdata_rd; the state ends on the 8th pull.
REQ-022 RD_BURST SHALL shift sdram_rdata into rdata on each sdram_rdata_vld, first beat to bits 127:112; the state ends on the 8th beat.
REQ-023 DONE SHALL pulse exactly the granted port's done for one cycle, then return to IDLE; the next grant is earliest the cycle after.
REQ-024 A beat counter SHALL be 3 bits, wrap 7->0, and be cleared on grant.
REQ-025 A timeout counter SHALL run from ISSUE entry; on reaching TIMEOUT it SHALL go to DONE with err and done pulsed together, rdata undefined, sdram_req low.
REQ-026 Pull/valid strobes arriving in IDLE or DONE SHALL be ignored, with no counter change.
REQ-027 A requester dropping req before its done is a protocol violation (bench assertion); the arbiter SHALL still complete the latched transaction.
REQ-028 Simultaneous new req and done on the same port: the new req SHALL NOT be granted in the done cycle.

Reset
REQ-029 On rst, FSM SHALL be IDLE, all outputs 0, rdata 0, counters 0, and RR pointer set to favour the D-cache.
REQ-030 rst mid-burst SHALL abort with no done pulse; the SDRAM controller shares rst.

Structure
REQ-031 Arbiter state enum, port-id type, 128-bit line_t and MEM_ACCESS_TIMEOUT SHALL live in mem_defines.
REQ-032 The 128<->8x16 serialise/deserialise SHALL be sub-module mem_line_serdes; arbitration and FSM stay in mem_arbiter.

Verification
REQ-033 Test: dc refill of addr 0x0000_1230, SDRAM returns 0x1111..0x8888 -> sdram_addr 0x000918, rdata 0x1111_2222_..._8888, one dc_done.
REQ-034 Test: ic writeback of addr 0x0100_0040, wdata 0xA0A1..A7 pattern -> 8 pulls output beats in order w0..w7, one ic_done, dc_done stays 0.
REQ-035 Test: dc_req and ic_req raised in the same cycle, both held -> order dc, ic, dc, ic (round-robin) over 4 transactions.
REQ-036 Test: sdram_ack never asserted -> after 128 cycles dc_err and dc_done high for exactly one cycle, FSM back in IDLE.
REQ-037 Test: rst asserted at read beat 4, then a new dc refill -> no done for the aborted access, and the new rdata is correct with no stale beats.
REQ-038 Test: stray sdram_rdata_vld pulses in IDLE, then a refill -> rdata contains only the 8 beats of the refill.
